// File: rtl/ch8_pkg.sv
// ch8_pkg: shared definitions for the CHIP-8 sprite draw / clear engine.
//   FB_W_DEFAULT   framebuffer width in pixels (one row per framebuffer word)
//   FB_H_DEFAULT   framebuffer height in rows
//   ADDR_W_DEFAULT RAM address width
//   draw_state_t   engine FSM states
//   idx_width()    bits needed to index 'depth' entries (minimum 1)
package ch8_pkg;

    localparam int unsigned FB_W_DEFAULT   = 64;
    localparam int unsigned FB_H_DEFAULT   = 32;
    localparam int unsigned ADDR_W_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        CLEAR,
        DONE
    } draw_state_t;

    function automatic int unsigned idx_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < depth) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/ch8_row_merge.sv
// ch8_row_merge: combinational XOR of one sprite byte into one framebuffer row.
//   byte_i  sprite byte, MSB is the leftmost pixel
//   x0_i    starting column of the byte
//   row_i   current row contents, bit FB_W-1 is x=0
//   row_o   row with the sprite byte XORed in
//   hit_o   1 when any set sprite pixel lands on a set row pixel
// Build option: CH8_SPRITE_WRAP_EN makes pixels past the right edge wrap to
// column 0; without it they are clipped.
module ch8_row_merge
    import ch8_pkg::*;
#(
    parameter int unsigned FB_W = FB_W_DEFAULT,
    parameter int unsigned XW   = idx_width(FB_W_DEFAULT)
) (
    input  logic [7:0]      byte_i,
    input  logic [XW-1:0]   x0_i,
    input  logic [FB_W-1:0] row_i,
    output logic [FB_W-1:0] row_o,
    output logic            hit_o
);

    logic [FB_W-1:0] placed;
    logic [FB_W-1:0] mask;

    always_comb begin
        // Byte at x=0; shifting right moves it to higher columns.
        placed = {byte_i, {(FB_W-8){1'b0}}};
`ifdef CH8_SPRITE_WRAP_EN
        // Rotate right: bits leaving column FB_W-1 re-enter at column 0.
        mask = FB_W'({placed, placed} >> x0_i);
`else
        mask = placed >> x0_i;
`endif
        row_o = row_i ^ mask;
        hit_o = |(row_i & mask);
    end

endmodule

// File: rtl/ch8_sprite_draw.sv
// ch8_sprite_draw: execution engine for CHIP-8 DXYN (sprite draw) and 00E0
// (clear). Draw reads n sprite bytes from RAM at i_addr and XORs them into
// the framebuffer by row read-modify-write, reporting the VF collision flag.
// Clear writes zero to every row.
//   clk, reset        clock, synchronous active-high reset
//   draw_req/clr_req  operation requests, sampled only in IDLE; clear wins
//   vx, vy, n, i_addr sprite position, height and base address
//   busy, done        busy while working; done pulses one cycle at the end
//   collision         VF result, valid with done, held until next acceptance
//   mem_rd/mem_addr/mem_rdata  sprite RAM port, 1-cycle read latency
//   fb_rd/fb_addr/fb_rdata     framebuffer row read, 1-cycle read latency
//   fb_we/fb_wdata             framebuffer row write
// Build option: CH8_SPRITE_WRAP_EN disables edge clipping; columns and rows
// wrap and every draw covers all n rows.
module ch8_sprite_draw
    import ch8_pkg::*;
#(
    parameter int unsigned FB_W   = FB_W_DEFAULT,
    parameter int unsigned FB_H   = FB_H_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        draw_req,
    input  logic                        clr_req,
    input  logic [7:0]                  vx,
    input  logic [7:0]                  vy,
    input  logic [3:0]                  n,
    input  logic [ADDR_W-1:0]           i_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        collision,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [7:0]                  mem_rdata,
    output logic                        fb_rd,
    output logic [idx_width(FB_H)-1:0]  fb_addr,
    input  logic [FB_W-1:0]             fb_rdata,
    output logic                        fb_we,
    output logic [FB_W-1:0]             fb_wdata
);

    localparam int unsigned RW = idx_width(FB_H);
    localparam int unsigned XW = idx_width(FB_W);
    // Row counter must reach both n-1 (draw) and FB_H-1 (clear).
    localparam int unsigned CW = (RW > 4) ? RW : 4;

    draw_state_t       state_q, state_d;
    logic [CW-1:0]     r_q, r_d;
    logic [XW-1:0]     x0_q, x0_d;
    logic [RW-1:0]     y0_q, y0_d;
    logic [3:0]        n_q, n_d;
    logic [ADDR_W-1:0] ia_q, ia_d;
    logic              coll_q, coll_d;

    logic [FB_W-1:0]   merged;
    logic              hit;
    logic [RW-1:0]     draw_row;
    logic              last_row;
    logic              bottom_clip;

    ch8_row_merge #(
        .FB_W (FB_W),
        .XW   (XW)
    ) u_merge (
        .byte_i (mem_rdata),
        .x0_i   (x0_q),
        .row_i  (fb_rdata),
        .row_o  (merged),
        .hit_o  (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            n_q     <= '0;
            ia_q    <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            n_q     <= n_d;
            ia_q    <= ia_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        n_d      = n_q;
        ia_d     = ia_q;
        coll_d   = coll_q;
        busy     = 1'b0;
        done     = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        fb_rd    = 1'b0;
        fb_addr  = '0;
        fb_we    = 1'b0;
        fb_wdata = '0;

        // Truncation to RW bits gives the mod-FB_H row wrap.
        draw_row = RW'(32'(y0_q) + 32'(r_q));
        last_row = (32'(r_q) + 32'd1 == 32'(n_q));
`ifdef CH8_SPRITE_WRAP_EN
        bottom_clip = 1'b0;
`else
        bottom_clip = (32'(y0_q) + 32'(r_q) + 32'd1 >= FB_H);
`endif

        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    r_d     = '0;
                    coll_d  = 1'b0;
                    state_d = CLEAR;
                end else if (draw_req) begin
                    x0_d    = XW'(vx);
                    y0_d    = RW'(vy);
                    n_d     = n;
                    ia_d    = i_addr;
                    r_d     = '0;
                    coll_d  = 1'b0;
                    state_d = (n != 4'd0) ? READ : DONE;
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = ia_q + ADDR_W'(r_q);
                fb_rd    = 1'b1;
                fb_addr  = draw_row;
                state_d  = MERGE;
            end
            MERGE: begin
                busy     = 1'b1;
                fb_we    = 1'b1;
                fb_addr  = draw_row;
                fb_wdata = merged;
                coll_d   = coll_q | hit;
                if (last_row || bottom_clip) begin
                    state_d = DONE;
                end else begin
                    r_d     = r_q + CW'(1);
                    state_d = READ;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                fb_we    = 1'b1;
                fb_addr  = RW'(r_q);
                fb_wdata = '0;
                if (32'(r_q) == FB_H - 32'd1) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q + CW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign collision = coll_q;

endmodule

// File: tb/tb_ch8_sprite_draw.sv
module tb_ch8_sprite_draw;

    localparam int FBW = 64;
    localparam int FBH = 32;

`ifdef CH8_SPRITE_WRAP_EN
    localparam logic [63:0] CLIP_ROW = 64'hF00000000000000F;
    localparam int          BOT_LAT  = 9;
`else
    localparam logic [63:0] CLIP_ROW = 64'h000000000000000F;
    localparam int          BOT_LAT  = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        draw_req, clr_req;
    logic [7:0]  vx, vy;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic        busy, done, collision;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        fb_rd;
    logic [4:0]  fb_addr;
    logic [63:0] fb_rdata;
    logic        fb_we;
    logic [63:0] fb_wdata;

    always #5 clk = ~clk;

    ch8_sprite_draw #(.FB_W(64), .FB_H(32), .ADDR_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .draw_req  (draw_req),
        .clr_req   (clr_req),
        .vx        (vx),
        .vy        (vy),
        .n         (n),
        .i_addr    (i_addr),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .fb_rd     (fb_rd),
        .fb_addr   (fb_addr),
        .fb_rdata  (fb_rdata),
        .fb_we     (fb_we),
        .fb_wdata  (fb_wdata)
    );

    logic [7:0]  ram    [4096];
    logic [63:0] fb_mem [32];
    logic [63:0] ref_fb [32];
    logic        seed_req = 1'b0;
    logic [4:0]  exp_wa [$];
    logic [63:0] exp_wd [$];
    int          total = 0;
    int          bad   = 0;

    // RAM and framebuffer memories seen by the DUT.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
        if (fb_rd)  fb_rdata  <= fb_mem[fb_addr];
        if (seed_req) begin
            for (int r = 0; r < FBH; r++) fb_mem[r] <= ref_fb[r];
        end else if (fb_we) begin
            fb_mem[fb_addr] <= fb_wdata;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Every row write must match the next expected write from the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) check("done_not_busy", {63'd0, busy}, 64'd0);
            if (fb_we) begin
                if (exp_wa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr=%0d data=%h want none", fb_addr, fb_wdata);
                end else begin
                    check("wr_addr", {59'd0, fb_addr}, {59'd0, exp_wa[0]});
                    check("wr_data", fb_wdata, exp_wd[0]);
                    void'(exp_wa.pop_front());
                    void'(exp_wd.pop_front());
                end
            end
        end
    end

    // Reference draw on the pixel grid; only the first max_rows rows are
    // committed to the model (used for the reset-abort case).
    task automatic model_draw(input logic [7:0] px, input logic [7:0] py, input logic [3:0] nn,
                              input logic [11:0] ia, input int max_rows,
                              output int lat, output logic coll);
        int rows;
        int y;
        int x;
        logic [7:0]  b;
        logic [63:0] row;
        bit stop;
        rows = 0;
        coll = 1'b0;
        stop = 1'b0;
        for (int k = 0; k < int'(nn); k++) begin
            y = int'(py) % FBH + k;
            if (y >= FBH) begin
`ifdef CH8_SPRITE_WRAP_EN
                y = y % FBH;
`else
                stop = 1'b1;
`endif
            end
            if (!stop) begin
                b   = ram[(int'(ia) + k) % 4096];
                row = ref_fb[y];
                for (int j = 0; j < 8; j++) begin
                    x = int'(px) % FBW + j;
`ifdef CH8_SPRITE_WRAP_EN
                    x = x % FBW;
`endif
                    if (x < FBW && b[7-j]) begin
                        if (row[FBW-1-x]) coll = 1'b1;
                        row[FBW-1-x] = ~row[FBW-1-x];
                    end
                end
                rows++;
                if (k < max_rows) begin
                    ref_fb[y] = row;
                    exp_wa.push_back(5'(y));
                    exp_wd.push_back(row);
                end
            end
        end
        lat = 2 * rows + 1;
    endtask

    task automatic model_clear(output int lat, output logic coll);
        for (int r = 0; r < FBH; r++) begin
            ref_fb[r] = '0;
            exp_wa.push_back(5'(r));
            exp_wd.push_back(64'd0);
        end
        lat  = FBH + 1;
        coll = 1'b0;
    endtask

    task automatic check_fb(input string nm);
        int m;
        m = 0;
        for (int r = 0; r < FBH; r++) if (fb_mem[r] !== ref_fb[r]) m++;
        check(nm, 64'(m), 64'd0);
    endtask

    // Issue one request, then count cycles from acceptance to done.
    // poke > 0 raises draw_req for 3 cycles mid-operation.
    task automatic run_op(input string nm, input logic dr, input logic cr,
                          input logic [7:0] px, input logic [7:0] py, input logic [3:0] nn,
                          input logic [11:0] ia, input int exp_lat, input logic exp_coll,
                          input int poke, output int cyc);
        @(negedge clk);
        draw_req = dr;
        clr_req  = cr;
        vx       = px;
        vy       = py;
        n        = nn;
        i_addr   = ia;
        @(posedge clk);
        #1;
        draw_req = 1'b0;
        clr_req  = 1'b0;
        cyc = 1;
        if (exp_lat > 1) check({nm, "_busy"}, {63'd0, busy}, 64'd1);
        while (!done && cyc < 300) begin
            if (cyc == poke)     draw_req = 1'b1;
            if (cyc == poke + 3) draw_req = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        draw_req = 1'b0;
        check({nm, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({nm, "_coll"}, {63'd0, collision}, {63'd0, exp_coll});
        @(negedge clk);
        @(negedge clk);
        check({nm, "_pending"}, 64'(exp_wa.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   cyc;
        logic coll;

        reset    = 1'b1;
        draw_req = 1'b0;
        clr_req  = 1'b0;
        vx       = '0;
        vy       = '0;
        n        = '0;
        i_addr   = '0;
        for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
        ram[12'h050] = 8'hF0; ram[12'h051] = 8'h90; ram[12'h052] = 8'h90;
        ram[12'h053] = 8'h90; ram[12'h054] = 8'hF0;
        ram[12'h100] = 8'hFF;
        ram[12'h200] = 8'h81; ram[12'h201] = 8'h42; ram[12'h202] = 8'h24; ram[12'h203] = 8'h18;
        ram[12'h300] = 8'hA5; ram[12'h301] = 8'h3C; ram[12'h302] = 8'h7E;
        ram[12'hFFF] = 8'hC3; ram[12'h000] = 8'h3C;
        for (int r = 0; r < FBH; r++) ref_fb[r] = {$urandom, $urandom};

        seed_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        seed_req = 1'b0;
        check("reset_outs", 64'({busy, done, collision, mem_rd, fb_rd, fb_we, mem_addr, fb_addr}), 64'd0);
        check("reset_wdata", fb_wdata, 64'd0);
        reset = 1'b0;

        // Clear a random framebuffer.
        model_clear(lat, coll);
        run_op("clear", 1'b0, 1'b1, 8'd0, 8'd0, 4'd0, 12'h000, lat, coll, -1, cyc);
        check("clear_lat_lit", 64'(cyc), 64'd33);
        check_fb("clear_fb");

        // Digit 0 glyph onto blank, then again to erase with collision.
        model_draw(8'd0, 8'd0, 4'd5, 12'h050, 15, lat, coll);
        run_op("draw0", 1'b1, 1'b0, 8'd0, 8'd0, 4'd5, 12'h050, lat, coll, -1, cyc);
        check("draw0_lat_lit", 64'(cyc), 64'd11);
        check("draw0_row0_lit", fb_mem[0], 64'hF000000000000000);
        check("draw0_row2_lit", fb_mem[2], 64'h9000000000000000);
        check_fb("draw0_fb");

        model_draw(8'd0, 8'd0, 4'd5, 12'h050, 15, lat, coll);
        run_op("redraw0", 1'b1, 1'b0, 8'd0, 8'd0, 4'd5, 12'h050, lat, coll, -1, cyc);
        check("redraw0_coll_lit", {63'd0, collision}, 64'd1);
        check("redraw0_row0_lit", fb_mem[0], 64'd0);
        repeat (3) @(negedge clk);
        check("coll_held", {63'd0, collision}, 64'd1);

        // n == 0: immediate done, no writes, collision cleared.
        model_draw(8'd3, 8'd3, 4'd0, 12'h050, 15, lat, coll);
        run_op("n0", 1'b1, 1'b0, 8'd3, 8'd3, 4'd0, 12'h050, lat, coll, -1, cyc);
        check("n0_lat_lit", 64'(cyc), 64'd1);

        // Right edge.
        model_draw(8'd60, 8'd10, 4'd1, 12'h100, 15, lat, coll);
        run_op("rclip", 1'b1, 1'b0, 8'd60, 8'd10, 4'd1, 12'h100, lat, coll, -1, cyc);
        check("rclip_row_lit", fb_mem[10], CLIP_ROW);
        check_fb("rclip_fb");

        // Bottom edge, then the same rows via vy wrap (62 mod 32 = 30).
        model_draw(8'd0, 8'd30, 4'd4, 12'h200, 15, lat, coll);
        run_op("bclip", 1'b1, 1'b0, 8'd0, 8'd30, 4'd4, 12'h200, lat, coll, -1, cyc);
        check("bclip_lat_lit", 64'(cyc), 64'(BOT_LAT));
        check("bclip_row30_lit", fb_mem[30], 64'h8100000000000000);
        model_draw(8'd0, 8'd62, 4'd4, 12'h200, 15, lat, coll);
        run_op("bwrap", 1'b1, 1'b0, 8'd0, 8'd62, 4'd4, 12'h200, lat, coll, -1, cyc);
        check("bwrap_row30_lit", fb_mem[30], 64'd0);
        check("bwrap_coll_lit", {63'd0, collision}, 64'd1);
        check_fb("bwrap_fb");

        // Unaligned column, and an I that wraps past the top of RAM.
        model_draw(8'd5, 8'd3, 4'd3, 12'h300, 15, lat, coll);
        run_op("straddle", 1'b1, 1'b0, 8'd5, 8'd3, 4'd3, 12'h300, lat, coll, -1, cyc);
        check("straddle_row3_lit", fb_mem[3], 64'h0528000000000000);
        model_draw(8'd20, 8'd7, 4'd2, 12'hFFF, 15, lat, coll);
        run_op("iwrap", 1'b1, 1'b0, 8'd20, 8'd7, 4'd2, 12'hFFF, lat, coll, -1, cyc);
        check_fb("iwrap_fb");

        // Clear wins over a simultaneous draw.
        model_clear(lat, coll);
        run_op("clr_and_draw", 1'b1, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, lat, coll, -1, cyc);
        check_fb("clr_and_draw_fb");

        // Draw request while busy is ignored.
        model_draw(8'd8, 8'd8, 4'd3, 12'h300, 15, lat, coll);
        run_op("predraw", 1'b1, 1'b0, 8'd8, 8'd8, 4'd3, 12'h300, lat, coll, -1, cyc);
        model_clear(lat, coll);
        run_op("busy_ignore", 1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, lat, coll, 5, cyc);
        repeat (4) @(negedge clk);
        check_fb("busy_ignore_fb");

        // Reset during cycle 3 of a draw: one row written, then nothing.
        model_draw(8'd0, 8'd0, 4'd5, 12'h050, 1, lat, coll);
        @(negedge clk);
        draw_req = 1'b1;
        vx = 8'd0; vy = 8'd0; n = 4'd5; i_addr = 12'h050;
        @(posedge clk);
        #1;
        draw_req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_outs", 64'({busy, done, fb_we, fb_rd, mem_rd}), 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_pending", 64'(exp_wa.size()), 64'd0);
        check("rst_mid_row0_lit", fb_mem[0], 64'hF000000000000000);
        check_fb("rst_mid_fb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
